forwarding_control: RTL

Hazard-detection and forwarding-control block for the 5-stage pipelined MIPS datapath. It sits at the ID/EX boundary and tracks the destination registers of the instructions in EX and MEM. For each instruction it registers the three Execute-stage mux selects (operand 1, operand 2, store data) so they are valid while that instruction is in EX. It also raises a one-cycle stall on load-use hazards and inserts a bubble into EX.

---
 rtl/forwarding_control.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/forwarding_control.sv
// Hazard detection and forwarding control at the ID/EX boundary of a 5-stage MIPS pipeline.
// Optional feature: define FWD_STALL_COUNT_EN to enable the saturating-free stall-cycle counter.
module forwarding_control #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IDRs,
  input  logic [REG_ADDR_W-1:0] IDRt,
  input  logic                  IDUsesRs,
  input  logic                  IDUsesRt,
  input  logic                  IDIsStore,
  input  logic [REG_ADDR_W-1:0] IDDestReg,
  input  logic                  IDRegWrite,
  input  logic                  IDMemRead,
  input  logic                  Flush,
  output logic [1:0]            Register1DataSelection,
  output logic [1:0]            Register2DataSelection,
  output logic [1:0]            StoreSelection,
  output logic                  EXBubble,
  output logic                  Stall,
  output logic [CNT_W-1:0]      StallCount
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic [REG_ADDR_W-1:0] ex_dest_r;
  logic                  ex_reg_write_r;
  logic                  ex_mem_read_r;
  logic [REG_ADDR_W-1:0] mem_dest_r;
  logic                  mem_reg_write_r;

  logic [1:0] sel1_r;
  logic [1:0] sel2_r;
  logic [1:0] sels_r;
  logic       bubble_r;

  logic [1:0] sel1_s;
  logic [1:0] sel2_s;
  logic [1:0] sels_s;
  logic       load_hit_s;
  logic       stall_s;
  logic       bubble_s;

  // EX holds the youngest value, so it wins over MEM; register 0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  used,
    input logic                  ex_wr,
    input logic [REG_ADDR_W-1:0] ex_dest,
    input logic                  mem_wr,
    input logic [REG_ADDR_W-1:0] mem_dest
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (used && (src != REG_ZERO)) begin
      if (ex_wr && (ex_dest == src)) begin
        sel = SEL_EX;
      end else if (mem_wr && (mem_dest == src)) begin
        sel = SEL_MEM;
      end else begin
        sel = SEL_RF;
      end
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  function automatic logic src_match(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  used,
    input logic [REG_ADDR_W-1:0] dest
  );
    return used && (src == dest);
  endfunction

  // Forwarding selects and load-use detection for the instruction in ID.
  always_comb begin
    sel1_s     = SEL_RF;
    sel2_s     = SEL_RF;
    sels_s     = SEL_RF;
    load_hit_s = 1'b0;
    stall_s    = 1'b0;
    bubble_s   = 1'b0;

    sel1_s = fwd_select(IDRs, IDUsesRs, ex_reg_write_r, ex_dest_r, mem_reg_write_r, mem_dest_r);
    sel2_s = fwd_select(IDRt, IDUsesRt, ex_reg_write_r, ex_dest_r, mem_reg_write_r, mem_dest_r);
    sels_s = fwd_select(IDRt, IDIsStore, ex_reg_write_r, ex_dest_r, mem_reg_write_r, mem_dest_r);

    if (ex_mem_read_r && ex_reg_write_r && (ex_dest_r != REG_ZERO)) begin
      load_hit_s = src_match(IDRs, IDUsesRs, ex_dest_r)
                 | src_match(IDRt, IDUsesRt, ex_dest_r)
                 | src_match(IDRt, IDIsStore, ex_dest_r);
    end else begin
      load_hit_s = 1'b0;
    end

    // A squashed instruction cannot cause a stall.
    if (Flush) begin
      stall_s = 1'b0;
    end else begin
      stall_s = load_hit_s;
    end
    bubble_s = stall_s | Flush;
  end

  // Pipeline shadow of destination info plus registered EX-stage selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_dest_r       <= REG_ZERO;
      ex_reg_write_r  <= 1'b0;
      ex_mem_read_r   <= 1'b0;
      mem_dest_r      <= REG_ZERO;
      mem_reg_write_r <= 1'b0;
      sel1_r          <= SEL_RF;
      sel2_r          <= SEL_RF;
      sels_r          <= SEL_RF;
      bubble_r        <= 1'b0;
    end else begin
      mem_dest_r      <= ex_dest_r;
      mem_reg_write_r <= ex_reg_write_r;
      if (bubble_s) begin
        ex_dest_r      <= REG_ZERO;
        ex_reg_write_r <= 1'b0;
        ex_mem_read_r  <= 1'b0;
        sel1_r         <= SEL_RF;
        sel2_r         <= SEL_RF;
        sels_r         <= SEL_RF;
        bubble_r       <= 1'b1;
      end else begin
        ex_dest_r      <= IDDestReg;
        ex_reg_write_r <= IDRegWrite;
        ex_mem_read_r  <= IDMemRead;
        sel1_r         <= sel1_s;
        sel2_r         <= sel2_s;
        sels_r         <= sels_s;
        bubble_r       <= 1'b0;
      end
    end
  end

`ifdef FWD_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Free-running stall-cycle counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign StallCount = stall_cnt_r;
`else
  assign StallCount = {CNT_W{1'b0}};
`endif

  assign Register1DataSelection = sel1_r;
  assign Register2DataSelection = sel2_r;
  assign StoreSelection         = sels_r;
  assign EXBubble               = bubble_r;
  assign Stall                  = stall_s;

endmodule
